// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] MULDIV_MUL    = 3'd0;
  localparam logic [2:0] MULDIV_MULH   = 3'd1;
  localparam logic [2:0] MULDIV_MULHSU = 3'd2;
  localparam logic [2:0] MULDIV_MULHU  = 3'd3;
  localparam logic [2:0] MULDIV_DIV    = 3'd4;
  localparam logic [2:0] MULDIV_DIVU   = 3'd5;
  localparam logic [2:0] MULDIV_REM    = 3'd6;
  localparam logic [2:0] MULDIV_REMU   = 3'd7;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/muldiv_if.sv
// Issue/writeback bundle between the core and the mul/div unit.
interface muldiv_if;
  import muldiv_pkg::*;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  modport master (output start, funct3, op_a, op_b, rd_in, flush,
                  input  stall, busy, wb_we, wb_addr, wb_data);
  modport slave  (input  start, funct3, op_a, op_b, rd_in, flush,
                  output stall, busy, wb_we, wb_addr, wb_data);
endinterface

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude/sign extraction and final conditional two's-complement negation.
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] mag_a,
  output logic [31:0] mag_b,
  output logic        sign_a,
  output logic        sign_b,
  input  logic        neg_en,
  input  logic [63:0] raw,
  output logic [63:0] fixed
);
  logic signed_a, signed_b;

  always_comb begin
    signed_a = funct3 inside {MULDIV_MUL, MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM};
    signed_b = funct3 inside {MULDIV_MUL, MULDIV_MULH, MULDIV_DIV, MULDIV_REM};
    sign_a   = signed_a & op_a[31];
    sign_b   = signed_b & op_b[31];
    mag_a    = sign_a ? (~op_a + 32'd1) : op_a;
    mag_b    = sign_b ? (~op_b + 32'd1) : op_b;
    fixed    = neg_en ? (~raw + 64'd1) : raw;
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: radix-2 shift-add multiply, restoring divide, one bit per cycle.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  import muldiv_pkg::*;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [4:0]        wb_addr_q, wb_addr_d;

  logic [XLEN-1:0]   mag_a, mag_b;
  logic              sign_a, sign_b;
  logic              neg_en;
  logic [2*XLEN-1:0] raw, fixed, step_nxt;
  logic [XLEN:0]     mul_sum, trial, diff;
  logic              is_div, div_zero, ovf;
  logic [XLEN-1:0]   spec_res, result;

  muldiv_sign_fix u_sign_fix (
    .funct3 (bus.funct3),
    .op_a   (bus.op_a),
    .op_b   (bus.op_b),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .sign_a (sign_a),
    .sign_b (sign_b),
    .neg_en (neg_en),
    .raw    (raw),
    .fixed  (fixed)
  );

  // acc holds {partial product / remainder, multiplier / quotient}; opnd is multiplicand or divisor
  always_comb begin
    is_div   = f3_q[2];
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    trial    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff     = trial - {1'b0, opnd_q};
    if (!is_div)
      step_nxt = {mul_sum, acc_q[XLEN-1:1]};
    else if (!diff[XLEN])
      step_nxt = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      step_nxt = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    if (!is_div) begin
      raw    = step_nxt;
      neg_en = sa_q ^ sb_q;
    end else begin
      raw    = {{XLEN{1'b0}}, f3_q[1] ? step_nxt[2*XLEN-1:XLEN] : step_nxt[XLEN-1:0]};
      neg_en = f3_q[1] ? sa_q : (sa_q ^ sb_q);
    end
    result = (is_div || f3_q == MULDIV_MUL) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
  end

  always_comb begin
    div_zero = bus.funct3[2] && (bus.op_b == '0);
    ovf      = (bus.funct3 == MULDIV_DIV || bus.funct3 == MULDIV_REM) &&
               (bus.op_a == INT_MIN) && (bus.op_b == '1);
    if (div_zero)
      spec_res = bus.funct3[1] ? bus.op_a : DIV_ZERO_Q;
    else
      spec_res = bus.funct3[1] ? '0 : INT_MIN;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    unique case (state_q)
      IDLE: if (bus.start && !bus.flush) begin
        f3_d  = bus.funct3;
        rd_d  = bus.rd_in;
        sa_d  = sign_a;
        sb_d  = sign_b;
        cnt_d = '0;
        if (div_zero || ovf) begin
          state_d   = DONE;
          wb_data_d = spec_res;
          wb_addr_d = bus.rd_in;
        end else begin
          state_d = CALC;
          opnd_d  = bus.funct3[2] ? mag_b : mag_a;
          acc_d   = {{XLEN{1'b0}}, bus.funct3[2] ? mag_a : mag_b};
        end
      end
      CALC: if (bus.flush) begin
        state_d = IDLE;
      end else begin
        acc_d = step_nxt;
        cnt_d = cnt_q + 5'd1;
        // final iteration: negate and latch the result on the way into DONE
        if (cnt_q == 5'(ITER-1)) begin
          state_d   = DONE;
          wb_data_d = result;
          wb_addr_d = rd_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      wb_data_q <= '0;
      wb_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
    end
  end

  assign bus.stall   = ((state_q == IDLE) && bus.start) || (state_q == CALC);
  assign bus.busy    = (state_q != IDLE);
  assign bus.wb_we   = (state_q == DONE) && !bus.flush && (rd_q != '0);
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, rd=0, ignored restart, flush and mid-op reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;

  muldiv_if bus();

  muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one op, count stall cycles up to DONE, check the writeback pulse and return to IDLE.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int exp_stall, input bit inject);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
    #1;
    n = 0;
    while (bus.stall === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
      bus.start = inject && (n == 5);
      if (inject && n == 5) begin
        bus.op_a = 32'd100; bus.rd_in = 5'd9;
      end
      #1;
    end
    bus.start = 1'b0;
    chk({tag, " stall_cycles"}, 32'(n), 32'(exp_stall));
    chk({tag, " busy_done"}, 32'(bus.busy), 32'd1);
    chk({tag, " wb_we"}, 32'(bus.wb_we), (rd != 5'd0) ? 32'd1 : 32'd0);
    chk({tag, " wb_addr"}, 32'(bus.wb_addr), 32'(rd));
    chk({tag, " wb_data"}, bus.wb_data, exp);
    @(negedge clk); #1;
    chk({tag, " idle_after"}, {30'd0, bus.busy, bus.wb_we}, 32'd0);
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.funct3 = 3'd0; bus.op_a = '0; bus.op_b = '0;
    bus.rd_in = '0;   bus.flush  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset outputs", {bus.wb_data[28:0], bus.stall, bus.busy, bus.wb_we}, 32'd0);
    chk("reset wb_addr", 32'(bus.wb_addr), 32'd0);
    chk("reset wb_data", bus.wb_data, 32'd0);
    @(negedge clk); rst = 1'b1;

    run_op("mul 7x6",       MULDIV_MUL,    32'd7,        32'd6,        5'd5,  32'd42,        33, 1'b0);
    run_op("mulh min*min",  MULDIV_MULH,   INT_MIN,      INT_MIN,      5'd1,  32'h4000_0000, 33, 1'b0);
    run_op("mulhsu -1*ffff",MULDIV_MULHSU, 32'hFFFF_FFFF,32'hFFFF_FFFF,5'd2,  32'hFFFF_FFFF, 33, 1'b0);
    run_op("mulhu ffff^2",  MULDIV_MULHU,  32'hFFFF_FFFF,32'hFFFF_FFFF,5'd3,  32'hFFFF_FFFE, 33, 1'b0);
    run_op("div -7/2",      MULDIV_DIV,    32'hFFFF_FFF9,32'd2,        5'd4,  32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem -7/2",      MULDIV_REM,    32'hFFFF_FFF9,32'd2,        5'd6,  32'hFFFF_FFFF, 33, 1'b0);
    run_op("divu 2000/6",   MULDIV_DIVU,   32'h2000,     32'd6,        5'd7,  32'h555,       33, 1'b0);
    run_op("remu 2000/6",   MULDIV_REMU,   32'h2000,     32'd6,        5'd8,  32'd2,         33, 1'b0);
    run_op("div by 0",      MULDIV_DIV,    32'h2004,     32'd0,        5'd10, 32'hFFFF_FFFF, 1,  1'b0);
    run_op("rem by 0",      MULDIV_REM,    32'h2004,     32'd0,        5'd11, 32'h2004,      1,  1'b0);
    run_op("div ovf",       MULDIV_DIV,    INT_MIN,      32'hFFFF_FFFF,5'd12, INT_MIN,       1,  1'b0);
    run_op("rem ovf",       MULDIV_REM,    INT_MIN,      32'hFFFF_FFFF,5'd13, 32'd0,         1,  1'b0);
    run_op("mul rd0 restart",MULDIV_MUL,   32'd3,        32'd3,        5'd0,  32'd9,         33, 1'b1);

    // the restart issued during CALC must not have produced a second operation
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (bus.busy === 1'b1 || bus.wb_we === 1'b1) n++;
    end
    chk("restart ignored", 32'(n), 32'd0);

    // flush after 10 CALC cycles
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = MULDIV_MUL; bus.op_a = 32'd5; bus.op_b = 32'd5; bus.rd_in = 5'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); bus.start = 1'b0;
    end
    bus.flush = 1'b1; #1;
    chk("flush busy in calc", 32'(bus.busy), 32'd1);
    chk("flush wb_we", 32'(bus.wb_we), 32'd0);
    @(negedge clk); bus.flush = 1'b0; #1;
    chk("flush idle", {30'd0, bus.busy, bus.stall}, 32'd0);
    chk("flush wb_data held", bus.wb_data, 32'd9);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (bus.wb_we === 1'b1) n++;
    end
    chk("flush no writeback", 32'(n), 32'd0);

    // asynchronous reset 20 cycles into CALC
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = MULDIV_DIV; bus.op_a = 32'd100; bus.op_b = 32'd7; bus.rd_in = 5'd4;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); bus.start = 1'b0;
    end
    rst = 1'b0; #1;
    chk("mid reset flags", {29'd0, bus.busy, bus.stall, bus.wb_we}, 32'd0);
    chk("mid reset wb_data", bus.wb_data, 32'd0);
    chk("mid reset wb_addr", 32'(bus.wb_addr), 32'd0);
    @(negedge clk); rst = 1'b1;
    run_op("after reset divu", MULDIV_DIVU, 32'd100, 32'd7, 5'd14, 32'd14, 33, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
